// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular byte FIFO; LSB-first frames with 1 or 2 stop bits.
// Optional even-parity bit is built only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int log2_fifosz = 4
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic [31:0]            i_scaler,
    input  logic                   i_stop2,
    input  logic                   i_parity_en,
    input  logic                   i_wvalid,
    input  logic [7:0]             i_wdata,
    output logic                   o_wready,
    output logic                   o_td,
    output logic                   o_busy,
    output logic                   o_fifo_empty,
    output logic                   o_fifo_full,
    output logic [log2_fifosz:0]   o_fifo_cnt,
    output logic                   o_tx_done
);

    localparam int DEPTH = 1 << log2_fifosz;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP1,
        ST_STOP2
    } state_t;

    logic [7:0]             mem_q [DEPTH];
    logic [log2_fifosz-1:0] wr_ptr_q;
    logic [log2_fifosz-1:0] rd_ptr_q;
    logic [log2_fifosz:0]   cnt_q;

    state_t      state_q;
    logic [7:0]  shift_q;
    logic [31:0] scaler_q;
    logic [31:0] timer_q;
    logic [2:0]  bit_cnt_q;
    logic        stop2_q;
    logic        td_q;
    logic        busy_q;
    logic        done_q;
`ifdef UART_TX_PARITY_EN
    logic        par_en_q;
    logic        par_q;
`else
    logic        unused_parity_en;
    assign unused_parity_en = i_parity_en;
`endif

    logic push;
    logic pop;
    logic bit_end;
    logic last_stop;

    assign o_fifo_empty = (cnt_q == '0);
    assign o_fifo_full  = (cnt_q == (log2_fifosz+1)'(DEPTH));
    assign o_wready     = !o_fifo_full;
    assign o_fifo_cnt   = cnt_q;
    assign o_td         = td_q;
    assign o_busy       = busy_q;
    assign o_tx_done    = done_q;

    assign push      = i_wvalid && o_wready;
    assign bit_end   = (timer_q == 32'd0);
    assign last_stop = (state_q == ST_STOP2) || ((state_q == ST_STOP1) && !stop2_q);
    // A frame starts either from idle or straight out of the final stop bit.
    assign pop       = !o_fifo_empty && ((state_q == ST_IDLE) || (last_stop && bit_end));

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scaler_q  <= '0;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            stop2_q   <= 1'b0;
            td_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (!bit_end) begin
                timer_q <= timer_q - 32'd1;
            end
            // td_q and done_q are set one edge early so they line up with the bit they describe.
            case (state_q)
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        td_q      <= shift_q[0];
                        timer_q   <= scaler_q;
                        bit_cnt_q <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q   <= shift_q >> 1;
                        timer_q   <= scaler_q;
                        bit_cnt_q <= bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                        par_q     <= par_q ^ shift_q[0];
`endif
                        if (bit_cnt_q != 3'd7) begin
                            td_q <= shift_q[1];
`ifdef UART_TX_PARITY_EN
                        end else if (par_en_q) begin
                            state_q <= ST_PARITY;
                            td_q    <= par_q ^ shift_q[0];
`endif
                        end else begin
                            state_q <= ST_STOP1;
                            td_q    <= 1'b1;
                            done_q  <= (scaler_q == 32'd0) && !stop2_q;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q <= ST_STOP1;
                        td_q    <= 1'b1;
                        timer_q <= scaler_q;
                        done_q  <= (scaler_q == 32'd0) && !stop2_q;
                    end
                end
`endif
                ST_STOP1, ST_STOP2: begin
                    if (!bit_end) begin
                        done_q <= last_stop && (timer_q == 32'd1);
                    end else if (!last_stop) begin
                        state_q <= ST_STOP2;
                        timer_q <= scaler_q;
                        done_q  <= (scaler_q == 32'd0);
                    end else begin
                        state_q <= ST_IDLE;
                        td_q    <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    td_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
            // Loading a new frame overrides whatever the state branch chose above.
            if (pop) begin
                state_q  <= ST_START;
                shift_q  <= mem_q[rd_ptr_q];
                scaler_q <= i_scaler;
                timer_q  <= i_scaler;
                stop2_q  <= i_stop2;
                td_q     <= 1'b0;
                busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                par_en_q <= i_parity_en;
                par_q    <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a bit-timed line receiver checks every frame it is told to expect.
// Parity expectations follow UART_TX_PARITY_EN, matching the build of the design.
module tb_uart_tx_fifo;

    localparam int NPAR =
`ifdef UART_TX_PARITY_EN
        1;
`else
        0;
`endif

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic [31:0] i_scaler;
    logic        i_stop2;
    logic        i_parity_en;
    logic        i_wvalid;
    logic [7:0]  i_wdata;
    logic        o_wready;
    logic        o_td;
    logic        o_busy;
    logic        o_fifo_empty;
    logic        o_fifo_full;
    logic [4:0]  o_fifo_cnt;
    logic        o_tx_done;

    int n_total = 0;
    int n_bad   = 0;

    bit acc_a, acc_b, acc_c;
    int n_acc;
    int n_glitch;
    bit seen_start;

    always #5 i_clk = ~i_clk;

    uart_tx_fifo #(.log2_fifosz(4)) dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_scaler     (i_scaler),
        .i_stop2      (i_stop2),
        .i_parity_en  (i_parity_en),
        .i_wvalid     (i_wvalid),
        .i_wdata      (i_wdata),
        .o_wready     (o_wready),
        .o_td         (o_td),
        .o_busy       (o_busy),
        .o_fifo_empty (o_fifo_empty),
        .o_fifo_full  (o_fifo_full),
        .o_fifo_cnt   (o_fifo_cnt),
        .o_tx_done    (o_tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, output bit acc);
        @(negedge i_clk);
        acc      = o_wready;
        i_wvalid = 1'b1;
        i_wdata  = d;
        @(posedge i_clk);
        #1;
        i_wvalid = 1'b0;
    endtask

    // Samples every cycle of a frame at negedges, assuming s+1 cycles per bit.
    task automatic rx_frame(input int s, input int npar, input int nstop, input int max_wait,
                            output logic [7:0] data, output logic pbit,
                            output bit found, output bit shape_ok, output bit done_ok);
        logic first;
        logic v;
        int   nb;
        found    = 1'b0;
        shape_ok = 1'b1;
        done_ok  = 1'b1;
        data     = '0;
        pbit     = 1'b0;
        first    = 1'b0;
        for (int w = 0; w < max_wait && !found; w++) begin
            @(negedge i_clk);
            if (o_td === 1'b0) found = 1'b1;
        end
        if (!found) return;
        nb = 1 + 8 + npar + nstop;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c <= s; c++) begin
                if (b != 0 || c != 0) @(negedge i_clk);
                v = o_td;
                if (c == 0) first = v;
                else if (v !== first) shape_ok = 1'b0;
                if (o_tx_done !== ((b == nb - 1) && (c == s))) done_ok = 1'b0;
                if (o_busy !== 1'b1) shape_ok = 1'b0;
            end
            if (b == 0 && first !== 1'b0) shape_ok = 1'b0;
            else if (b >= 1 && b <= 8) data[b-1] = first;
            else if (npar != 0 && b == 9) pbit = first;
            else if (b >= 9 + npar && first !== 1'b1) shape_ok = 1'b0;
        end
        $display("rx frame byte=%02h par=%0d shape_ok=%0d done_ok=%0d", data, pbit, shape_ok, done_ok);
    endtask

    task automatic expect_frame(input string tag, input int s, input int npar, input int nstop,
                                input int max_wait, input logic [7:0] exp_d, input logic exp_p);
        logic [7:0] d;
        logic       p;
        bit         found, shape_ok, done_ok;
        rx_frame(s, npar, nstop, max_wait, d, p, found, shape_ok, done_ok);
        chk({tag, ".found"}, found, 1);
        if (found) begin
            chk({tag, ".data"}, d, exp_d);
            chk({tag, ".shape"}, shape_ok, 1);
            chk({tag, ".done"}, done_ok, 1);
            if (npar != 0) chk({tag, ".parity"}, p, exp_p);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_nrst = 1'b0; i_scaler = 32'd3; i_stop2 = 1'b0; i_parity_en = 1'b0;
        i_wvalid = 1'b0; i_wdata = 8'h00;
        repeat (2) @(negedge i_clk);
        chk("rst.td", o_td, 1);
        chk("rst.busy", o_busy, 0);
        chk("rst.done", o_tx_done, 0);
        chk("rst.empty", o_fifo_empty, 1);
        chk("rst.full", o_fifo_full, 0);
        chk("rst.cnt", o_fifo_cnt, 0);
        chk("rst.wready", o_wready, 1);
        i_nrst = 1'b1;

        // 8N1, 4 cycles per bit
        fork
            push(8'h55, acc_a);
            expect_frame("b55", 3, 0, 1, 20, 8'h55, 1'b0);
        join
        chk("b55.acc", acc_a, 1);
        @(negedge i_clk);
        chk("b55.idle_busy", o_busy, 0);
        chk("b55.idle_td", o_td, 1);

        // parity on/off at one cycle per bit
        i_scaler = 32'd0; i_parity_en = 1'b1;
        fork
            push(8'h07, acc_a);
            expect_frame("par07", 0, NPAR, 1, 20, 8'h07, 1'b1);
        join
        fork
            push(8'h03, acc_a);
            expect_frame("par03", 0, NPAR, 1, 20, 8'h03, 1'b0);
        join
        i_parity_en = 1'b0;
        fork
            push(8'h07, acc_a);
            expect_frame("nopar07", 0, 0, 1, 20, 8'h07, 1'b0);
        join

        // two stop bits, back-to-back frames
        i_scaler = 32'd1; i_stop2 = 1'b1;
        fork
            begin push(8'hFF, acc_a); push(8'h00, acc_b); end
            begin
                expect_frame("s2_ff", 1, 0, 2, 20, 8'hFF, 1'b0);
                expect_frame("s2_00", 1, 0, 2, 1, 8'h00, 1'b0);
            end
        join
        i_stop2 = 1'b0;

        // scaler changed mid-frame only affects the next frame
        i_scaler = 32'd3;
        fork
            begin push(8'h3C, acc_a); push(8'hC3, acc_b); end
            begin repeat (12) @(negedge i_clk); i_scaler = 32'd7; end
            begin
                expect_frame("sc3", 3, 0, 1, 20, 8'h3C, 1'b0);
                expect_frame("sc7", 7, 0, 1, 1, 8'hC3, 1'b0);
            end
        join

        // overfill: 20 offered, 17 held (16 in FIFO + 1 in shift register)
        i_scaler = 32'd2; n_acc = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push(8'h10 + 8'(i), acc_c);
                    n_acc += int'(acc_c);
                end
                @(negedge i_clk);
                chk("fill.accepted", n_acc, 17);
                chk("fill.cnt", o_fifo_cnt, 16);
                chk("fill.full", o_fifo_full, 1);
                chk("fill.wready", o_wready, 0);
            end
            begin
                for (int k = 0; k < 17; k++)
                    expect_frame($sformatf("fill%0d", k), 2, 0, 1, (k == 0) ? 20 : 1, 8'h10 + 8'(k), 1'b0);
            end
        join
        @(negedge i_clk);
        chk("fill.empty_after", o_fifo_empty, 1);
        chk("fill.busy_after", o_busy, 0);

        // reset during data bit 3 with a byte still queued
        i_scaler = 32'd3;
        push(8'h3C, acc_a);
        push(8'h99, acc_b);
        seen_start = 1'b0;
        for (int w = 0; w < 10 && !seen_start; w++) begin
            @(negedge i_clk);
            if (o_td === 1'b0) seen_start = 1'b1;
        end
        chk("rst_mid.start", seen_start, 1);
        repeat (17) @(negedge i_clk);
        #1 i_nrst = 1'b0;
        #1;
        chk("rst_mid.td", o_td, 1);
        chk("rst_mid.cnt", o_fifo_cnt, 0);
        chk("rst_mid.busy", o_busy, 0);
        chk("rst_mid.empty", o_fifo_empty, 1);
        @(negedge i_clk);
        i_nrst = 1'b1;
        n_glitch = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_td !== 1'b1 || o_busy !== 1'b0) n_glitch++;
        end
        chk("rst_mid.quiet", n_glitch, 0);
        fork
            push(8'hA5, acc_a);
            expect_frame("rst_a5", 3, 0, 1, 20, 8'hA5, 1'b0);
        join

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
